// File: rtl/uart_cfg_writer.sv
// Snapshots a UART config on start and writes each masked field to the register file over valid/address/data/ack.
// Each write takes 2 cycles with an ack one cycle later, plus 1 guard cycle between writes; the request is held until ack or timeout.
module uart_cfg_writer #(
  parameter int         TIMEOUT     = 16,
  parameter logic [3:0] ADDR_PARITY = 4'b1001,
  parameter logic [3:0] ADDR_PTYPE  = 4'b1010,
  parameter logic [3:0] ADDR_STOP   = 4'b1011,
  parameter logic [3:0] ADDR_FLEN   = 4'b1100
) (
  input  logic       clk_16bd,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] write_mask,
  input  logic       cfg_parity,
  input  logic       cfg_parity_type,
  input  logic       cfg_stop_bits,
  input  logic [3:0] cfg_frame_length,
  input  logic       ack,
  output logic       valid,
  output logic [3:0] address,
  output logic [3:0] data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [3:0] pend;
  logic       snap_parity;
  logic       snap_ptype;
  logic       snap_stop;
  logic [3:0] snap_flen;
  logic [7:0] tmo_cnt;
  logic [3:0] pend_left;

  function automatic logic [3:0] lowbit(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

  function automatic logic [3:0] field_addr(input logic [3:0] sel);
    if (sel[0])      return ADDR_PARITY;
    else if (sel[1]) return ADDR_PTYPE;
    else if (sel[2]) return ADDR_STOP;
    else if (sel[3]) return ADDR_FLEN;
    else             return 4'd0;
  endfunction

  function automatic logic [3:0] field_data(input logic [3:0] sel, input logic par,
                                            input logic ptype, input logic stop,
                                            input logic [3:0] flen);
    if (sel[0])      return {3'b000, par};
    else if (sel[1]) return {3'b000, ptype};
    else if (sel[2]) return {3'b000, stop};
    else if (sel[3]) return flen;
    else             return 4'd0;
  endfunction

  assign pend_left = pend & ~lowbit(pend);

  always_ff @(posedge clk_16bd or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= 4'd0;
      snap_parity <= 1'b0;
      snap_ptype  <= 1'b0;
      snap_stop   <= 1'b0;
      snap_flen   <= 4'd0;
      tmo_cnt     <= 8'd0;
      valid       <= 1'b0;
      address     <= 4'd0;
      data        <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            pend        <= write_mask;
            snap_parity <= cfg_parity;
            snap_ptype  <= cfg_parity_type;
            snap_stop   <= cfg_stop_bits;
            snap_flen   <= cfg_frame_length;
            tmo_cnt     <= 8'd0;
            error       <= 1'b0;
            busy        <= 1'b1;
            if (write_mask != 4'd0) begin
              state   <= REQ;
              valid   <= 1'b1;
              address <= field_addr(lowbit(write_mask));
              data    <= field_data(lowbit(write_mask), cfg_parity, cfg_parity_type,
                                    cfg_stop_bits, cfg_frame_length);
            end else begin
              state <= DONE;
            end
          end
        end
        REQ: begin
          // ack has priority over a timeout on the same edge
          if (ack) begin
            valid <= 1'b0;
            pend  <= pend_left;
            state <= (pend_left != 4'd0) ? GAP : DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            error <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        GAP: begin
          state   <= REQ;
          valid   <= 1'b1;
          tmo_cnt <= 8'd0;
          address <= field_addr(lowbit(pend));
          data    <= field_data(lowbit(pend), snap_parity, snap_ptype, snap_stop, snap_flen);
        end
        DONE: begin
          // busy stays high through the done cycle and drops in IDLE
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_writer.sv
// Directed bench for uart_cfg_writer with a register-file ack model and an expected-write queue.
module tb_uart_cfg_writer;

  logic       clk_16bd = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] write_mask = 4'd0;
  logic       cfg_parity = 1'b0;
  logic       cfg_parity_type = 1'b0;
  logic       cfg_stop_bits = 1'b0;
  logic [3:0] cfg_frame_length = 4'd0;
  logic       ack = 1'b0;
  logic       valid;
  logic [3:0] address;
  logic [3:0] data;
  logic       busy;
  logic       done;
  logic       error;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t_start = 0;
  int         writes_in_seq = 0;
  int         gap_len = 0;
  int         done_cnt = 0;
  bit         ack_en = 1'b1;
  logic       valid_d = 1'b0;
  logic [7:0] cur_wr = 8'd0;
  logic [7:0] exp_q[$];

  uart_cfg_writer #(.TIMEOUT(8)) dut (
    .clk_16bd        (clk_16bd),
    .rst_n           (rst_n),
    .start           (start),
    .write_mask      (write_mask),
    .cfg_parity      (cfg_parity),
    .cfg_parity_type (cfg_parity_type),
    .cfg_stop_bits   (cfg_stop_bits),
    .cfg_frame_length(cfg_frame_length),
    .ack             (ack),
    .valid           (valid),
    .address         (address),
    .data            (data),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk_16bd = ~clk_16bd;

  initial forever begin
    @(posedge clk_16bd);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register file: acks for one cycle, one cycle after it samples valid.
  initial begin : ack_model
    logic v;
    forever begin
      @(posedge clk_16bd);
      v = valid;
      #1;
      ack = ack_en && v && !ack;
    end
  end

  // Write monitor: pops the scoreboard on each new request.
  initial forever begin
    @(negedge clk_16bd);
    if (!rst_n) begin
      valid_d = 1'b0;
    end else begin
      if (valid && !valid_d) begin
        if (writes_in_seq > 0) check("gap_len", 32'(gap_len), 32'd1);
        check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cur_wr = exp_q.pop_front();
          check("wr_addr_data", 32'({address, data}), 32'(cur_wr));
        end else begin
          cur_wr = {address, data};
        end
        writes_in_seq++;
      end else if (valid) begin
        check("wr_stable", 32'({address, data}), 32'(cur_wr));
      end
      if (valid) gap_len = 0;
      else gap_len++;
      if (done) done_cnt++;
      valid_d = valid;
    end
  end

  function automatic logic [7:0] exp_word(input int i, input logic p, input logic pt,
                                          input logic sb, input logic [3:0] fl);
    case (i)
      0:       return {4'h9, 3'b000, p};
      1:       return {4'hA, 3'b000, pt};
      2:       return {4'hB, 3'b000, sb};
      default: return {4'hC, fl};
    endcase
  endfunction

  task automatic kick(input logic [3:0] m, input logic p, input logic pt,
                      input logic sb, input logic [3:0] fl);
    @(negedge clk_16bd);
    write_mask = m;
    cfg_parity = p;
    cfg_parity_type = pt;
    cfg_stop_bits = sb;
    cfg_frame_length = fl;
    start = 1'b1;
    for (int i = 0; i < 4; i++) if (m[i]) exp_q.push_back(exp_word(i, p, pt, sb, fl));
    writes_in_seq = 0;
    done_cnt = 0;
    @(posedge clk_16bd);
    #1;
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_16bd);
      if (done) begin
        lat = cyc - t_start;
        break;
      end
    end
  endtask

  task automatic finish_seq(input string tag);
    repeat (2) @(negedge clk_16bd);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int cnt_busy;
    int cnt_valid;
    bit found;

    repeat (2) @(negedge clk_16bd);
    check("reset_outputs", 32'({valid, address, data, busy, done, error}), 32'd0);
    rst_n = 1'b1;

    // full mask, writes 9:1 10:0 11:1 12:7
    kick(4'hF, 1'b1, 1'b0, 1'b1, 4'h7);
    check("full_busy", 32'(busy), 32'd1);
    wait_done(40, lat);
    check("full_latency", 32'(lat), 32'd12);
    finish_seq("full");
    check("full_writes", 32'(writes_in_seq), 32'd4);

    // single stop-bits write
    kick(4'b0100, 1'b0, 1'b0, 1'b1, 4'h3);
    wait_done(20, lat);
    check("sparse_latency", 32'(lat), 32'd3);
    finish_seq("sparse");
    check("sparse_writes", 32'(writes_in_seq), 32'd1);

    // empty mask goes straight to done
    kick(4'h0, 1'b1, 1'b1, 1'b1, 4'hF);
    cnt_busy = 1;
    cnt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_16bd);
      if (busy) cnt_busy++;
      if (valid) cnt_valid++;
    end
    check("zero_busy_cycles", 32'(cnt_busy - 1), 32'd2);
    check("zero_no_valid", 32'(cnt_valid), 32'd0);
    check("zero_done_once", 32'(done_cnt), 32'd1);

    // no ack: abort after TIMEOUT cycles on the first field
    ack_en = 1'b0;
    kick(4'hF, 1'b1, 1'b1, 1'b0, 4'h5);
    cnt_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_16bd);
      if (valid) cnt_valid++;
      if (!busy) break;
    end
    check("tmo_valid_cycles", 32'(cnt_valid), 32'd8);
    check("tmo_valid_low", 32'(valid), 32'd0);
    check("tmo_busy_low", 32'(busy), 32'd0);
    check("tmo_error", 32'(error), 32'd1);
    repeat (3) @(negedge clk_16bd);
    check("tmo_no_done", 32'(done_cnt), 32'd0);
    check("tmo_error_sticky", 32'(error), 32'd1);
    check("tmo_pending_left", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    ack_en = 1'b1;

    // next start clears the error
    kick(4'hF, 1'b0, 1'b1, 1'b1, 4'hA);
    check("err_cleared", 32'(error), 32'd0);
    wait_done(40, lat);
    check("recover_latency", 32'(lat), 32'd12);
    finish_seq("recover");

    // start while busy is ignored
    kick(4'hF, 1'b1, 1'b1, 1'b1, 4'h2);
    repeat (4) @(negedge clk_16bd);
    write_mask = 4'b0010;
    cfg_parity = 1'b0;
    cfg_parity_type = 1'b0;
    cfg_stop_bits = 1'b0;
    cfg_frame_length = 4'h9;
    start = 1'b1;
    @(posedge clk_16bd);
    #1;
    start = 1'b0;
    wait_done(40, lat);
    check("busy_prot_latency", 32'(lat), 32'd12);
    finish_seq("busy_prot");
    check("busy_prot_writes", 32'(writes_in_seq), 32'd4);

    // reset during the second write
    kick(4'hF, 1'b1, 1'b0, 1'b0, 4'hE);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_16bd);
      if (valid && address == 4'hA) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_addr10", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({valid, address, data, busy, done, error}), 32'd0);
    check("midreset_pending", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    repeat (2) @(negedge clk_16bd);
    rst_n = 1'b1;
    kick(4'hF, 1'b0, 1'b0, 1'b1, 4'h9);
    wait_done(40, lat);
    check("post_reset_latency", 32'(lat), 32'd12);
    finish_seq("post_reset");
    check("post_reset_writes", 32'(writes_in_seq), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cfg_writer.md
Name: uart_cfg_writer

Overview:
Initiator for the UART configuration register interface (valid/address/data with ack). On a start request it snapshots a full UART configuration (parity enable, parity type, stop bits, frame length) and issues one register write per selected field, in order, to the UART register file. Each write waits for ack, a guard cycle separates consecutive writes, and a timeout aborts the sequence if ack never arrives. It sits between the VGA-side control logic and the UART register file.

Parameters:
TIMEOUT, 16, cycles in REQ without ack before abort (legal range 2..255)
ADDR_PARITY, 4'b1001, register address for parity enable
ADDR_PTYPE, 4'b1010, register address for parity type
ADDR_STOP, 4'b1011, register address for stop bits
ADDR_FLEN, 4'b1100, register address for frame length

Ports:
clk_16bd  in  1  16x baud clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a write sequence; sampled only in IDLE
write_mask  in  4  bit0 parity, bit1 parity type, bit2 stop bits, bit3 frame length; 1 = write this field
cfg_parity  in  1  parity enable value
cfg_parity_type  in  1  parity type value
cfg_stop_bits  in  1  stop bits value
cfg_frame_length  in  4  frame length value
ack  in  1  write acknowledge from the register file (single-cycle pulse)
valid  out  1  write request; address and data are stable while high
address  out  4  target register address
data  out  4  write data
busy  out  1  high from the start edge until return to IDLE
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky timeout flag; cleared at the next accepted start

Behaviour:
- Reset (async, rst_n low): state IDLE, valid=0, address=0, data=0, busy=0, done=0, error=0, mask/config snapshot=0, timeout counter=0.
- Control is a registered Moore FSM with states IDLE, REQ, GAP, DONE. Every output is a flop.
- IDLE: on start=1, capture write_mask and all cfg_* into snapshot registers, clear error, set busy=1.
  - Snapshot mask nonzero: go to REQ, targeting the lowest set bit. valid=1 and address/data drive from the next cycle.
  - Snapshot mask zero: go directly to DONE.
- Field order: bit0 -> bit3, ascending address. Each field is cleared from the pending mask when its ack is taken.
- Data encoding: 1-bit fields send {3'b000, value}; frame length sends the 4-bit value unchanged.
- REQ: valid=1; address and data held constant.
  - ack=1 at an edge: valid=0 at that edge; clear the field's pending bit. Remaining bits go to GAP; none go to DONE.
  - No ack: timeout counter increments (reset to 0 on each REQ entry). When the counter reaches TIMEOUT-1 with ack low: valid=0, busy=0, error=1, go to IDLE, no done pulse.
  - ack and the timeout condition on the same edge: ack wins.
- GAP: exactly one cycle with valid=0, then REQ for the next pending field. This guarantees the register file's ack/lock cycle has completed before the next request.
- DONE: done=1 for exactly one cycle, busy still 1, then IDLE with busy=0, done=0.
- ack outside REQ is ignored. start outside IDLE is ignored; snapshot inputs may change freely while busy.
- Latency with the register file (ack one cycle after valid is sampled): 2 cycles per write plus 1 GAP between writes. Full mask: start edge to done pulse = 4x2 + 3 + 1 = 12 cycles.
- Reset asserted mid-sequence returns all state and outputs to reset values immediately. A partially written configuration is not rolled back.

Test Plan:
- Full mask: write_mask=4'hF, cfg=(1,0,1,4'h7), register-file model acks one cycle after valid -> writes in order 9:1, 10:0, 11:1, 12:7; valid low exactly one cycle between writes; done pulses once 12 cycles after the start edge; error=0.
- Sparse mask: write_mask=4'b0100, cfg_stop_bits=1 -> single write address 4'hB data 4'h1; then DONE, done=1 one cycle; no other addresses driven.
- Zero mask: write_mask=0, start=1 -> valid never asserts; busy high 2 cycles; done pulses once.
- Timeout: TIMEOUT=8, ack tied 0, full mask -> valid high for 8 cycles on address 9, then valid=0, busy=0, error=1, no done. Next start clears error.
- Busy protection: pulse start again mid-sequence with different cfg/mask -> ignored; original snapshot values written.
- Reset mid-operation: drop rst_n while valid=1 on address 10 -> all outputs 0 asynchronously. After release, a new start runs the full sequence correctly.
